// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a bus master/interconnect and one SRAM slave port.
interface ahb_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, byte-lane writes, two-cycle ERROR.
// Optional macro AHB_SRAM_SLAVE_ALIGN_CHECK_EN turns misaligned transfers into ERROR.
module ahb_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic hclk,
    input  logic hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(DEPTH_WORDS * 4);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Little-endian lane enables; low offset bits below the size alignment are ignored.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << off;
            3'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

`ifdef AHB_SRAM_SLAVE_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
        logic r;
        case (size)
            3'd1:    r = off[0];
            3'd2:    r = |off;
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

    state_t            state_r, state_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic              ready_r, ready_nxt_s;
    logic              resp_r, resp_nxt_s;
    logic [DATA_W-1:0] hrdata_r, hrdata_s;
    logic [IDX_W-1:0]  idx_r;
    logic [3:0]        mask_r;
    logic              write_r;

    logic accept_s, range_err_s, size_err_s, align_err_s, err_s, open_s;

    assign open_s      = (state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2);
    assign accept_s    = bus.hsel & bus.hready & bus.htrans[1] & open_s;
    assign range_err_s = ({1'b0, bus.haddr} >= BYTE_LIMIT);
    assign size_err_s  = (bus.hsize > 3'd2);
`ifdef AHB_SRAM_SLAVE_ALIGN_CHECK_EN
    assign align_err_s = misaligned(bus.hsize, bus.haddr[1:0]);
`else
    assign align_err_s = 1'b0;
`endif
    assign err_s = range_err_s | size_err_s | align_err_s;

    // Read data is live from the array only during a read completion; otherwise it holds.
    assign hrdata_s = ((state_r == ST_DATA) && !write_r) ? mem_r[idx_r] : hrdata_r;

    assign bus.hreadyout = ready_r;
    assign bus.hresp     = resp_r;
    assign bus.hrdata    = hrdata_s;

    // Next-state and next registered response values.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = 4'd0;
        ready_nxt_s = 1'b1;
        resp_nxt_s  = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r + 4'd1;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nxt_s = ST_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        case (state_nxt_s)
            ST_WAIT: ready_nxt_s = 1'b0;
            ST_ERR1: begin
                ready_nxt_s = 1'b0;
                resp_nxt_s  = 1'b1;
            end
            ST_ERR2: resp_nxt_s = 1'b1;
            default: begin
                ready_nxt_s = 1'b1;
                resp_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, wait counter and registered response outputs.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            ready_r  <= 1'b1;
            resp_r   <= 1'b0;
            hrdata_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            ready_r  <= ready_nxt_s;
            resp_r   <= resp_nxt_s;
            hrdata_r <= hrdata_s;
        end
    end

    // Address-phase capture of the accepted transfer.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            idx_r   <= '0;
            mask_r  <= 4'd0;
            write_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= bus.haddr[IDX_W+1:2];
            mask_r  <= lane_mask(bus.hsize, bus.haddr[1:0]);
            write_r <= bus.hwrite;
        end
    end

    // Write commits on the edge closing the data phase; reset discards it.
    always_ff @(posedge hclk) begin
        if (!hreset && (state_r == ST_DATA) && write_r) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: two slaves (WAIT_CYCLES 0 and 3) behind a tiny hready/response mux.
module tb_ahb_sram_slave;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    logic        hsel0, hsel3, hwrite, dsel_r, mon_en;
    logic [31:0] haddr, hwdata, hrdata_bus;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        hready_bus, hresp_bus;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus3 ();

    assign bus0.hsel = hsel0;   assign bus3.hsel = hsel3;
    assign bus0.haddr = haddr;  assign bus3.haddr = haddr;
    assign bus0.htrans = htrans; assign bus3.htrans = htrans;
    assign bus0.hwrite = hwrite; assign bus3.hwrite = hwrite;
    assign bus0.hsize = hsize;  assign bus3.hsize = hsize;
    assign bus0.hburst = hburst; assign bus3.hburst = hburst;
    assign bus0.hwdata = hwdata; assign bus3.hwdata = hwdata;
    assign bus0.hready = hready_bus; assign bus3.hready = hready_bus;

    assign hready_bus = dsel_r ? bus3.hreadyout : bus0.hreadyout;
    assign hresp_bus  = dsel_r ? bus3.hresp     : bus0.hresp;
    assign hrdata_bus = dsel_r ? bus3.hrdata    : bus0.hrdata;

    ahb_sram_slave #(.WAIT_CYCLES(0)) u_dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_sram_slave #(.WAIT_CYCLES(3)) u_dut3 (.hclk(hclk), .hreset(hreset), .bus(bus3));

    // Data-phase slave select for the response mux.
    always @(posedge hclk) begin
        if (hreset) dsel_r <= 1'b0;
        else if (hready_bus) dsel_r <= hsel3;
    end

    typedef struct {
        string       name;
        bit          is_read;
        logic [31:0] data;
        bit          resp;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input bit tgt, input logic [31:0] a, input logic [1:0] tr, input bit w,
                         input logic [2:0] sz, input logic [31:0] d, input bit push,
                         input string nm, input logic [31:0] ed, input bit er, input int ew);
        int n;
        n = 0;
        hsel0 = !tgt; hsel3 = tgt; haddr = a; htrans = tr; hwrite = w; hsize = sz;
        if (push) sb_q.push_back(exp_t'{nm, !w, ed, er, ew});
        while (!hready_bus && n < 50) begin
            @(posedge hclk); #1;
            n++;
        end
        if (n >= 50) check({nm, "_accept"}, {31'd0, hready_bus}, 32'd1);
        @(posedge hclk); #1;
        if (w && tr[1]) hwdata = d;
    endtask

    task automatic wr(input bit tgt, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input string nm, input logic [1:0] tr = T_NSEQ);
        issue(tgt, a, tr, 1'b1, sz, d, 1'b1, nm, 32'd0, 1'b0, tgt ? 3 : 0);
    endtask

    task automatic rd(input bit tgt, input logic [31:0] a, input logic [31:0] ed, input string nm);
        issue(tgt, a, T_NSEQ, 1'b0, 3'd2, 32'd0, 1'b1, nm, ed, 1'b0, tgt ? 3 : 0);
    endtask

    task automatic errx(input logic [31:0] a, input bit w, input logic [2:0] sz,
                        input logic [31:0] d, input string nm);
        issue(1'b0, a, T_NSEQ, w, sz, d, 1'b1, nm, 32'd0, 1'b1, 1);
    endtask

    task automatic idle(input int n);
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = T_IDLE;
        repeat (n) begin
            @(posedge hclk); #1;
        end
    endtask

    // Monitor: counts low-ready cycles per data phase and checks each completion.
    initial begin
        bit dp_active;
        int waits;
        exp_t e;
        dp_active = 1'b0;
        waits = 0;
        forever begin
            @(negedge hclk);
            if (mon_en) begin
                if (hreset) begin
                    dp_active = 1'b0;
                    waits = 0;
                end else if (!hready_bus) begin
                    if (dp_active) waits++;
                    else check("spurious_wait", {31'd0, hready_bus}, 32'd1);
                end else begin
                    if (dp_active) begin
                        if (sb_q.size() == 0) begin
                            check("sb_underflow", 32'(sb_q.size()), 32'd1);
                        end else begin
                            e = sb_q.pop_front();
                            check({e.name, "_resp"}, {31'd0, hresp_bus}, {31'd0, e.resp});
                            check({e.name, "_waits"}, 32'(waits), 32'(e.waits));
                            if (e.is_read && !e.resp) check({e.name, "_data"}, hrdata_bus, e.data);
                        end
                    end else begin
                        check("idle_okay", {31'd0, hresp_bus}, 32'd0);
                    end
                    dp_active = (hsel0 | hsel3) & htrans[1];
                    waits = 0;
                end
            end
        end
    end

    initial begin
        mon_en = 1'b0;
        hsel0 = 1'b0; hsel3 = 1'b0; haddr = 32'd0; htrans = T_IDLE; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hwdata = 32'd0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        check("rst_ready0", {31'd0, bus0.hreadyout}, 32'd1);
        check("rst_resp0", {31'd0, bus0.hresp}, 32'd0);
        check("rst_rdata0", bus0.hrdata, 32'd0);
        check("rst_ready3", {31'd0, bus3.hreadyout}, 32'd1);
        check("rst_rdata3", bus3.hrdata, 32'd0);
        mon_en = 1'b1;

        wr(1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF, "wr_word");
        rd(1'b0, 32'h10, 32'hDEAD_BEEF, "raw_word");
        wr(1'b0, 32'h10, 3'd2, 32'h0000_0000, "clr_word4");
        wr(1'b0, 32'h11, 3'd0, 32'h0000_AB00, "wr_byte");
        rd(1'b0, 32'h10, 32'h0000_AB00, "rd_byte");
        wr(1'b0, 32'h20, 3'd2, 32'h1122_3344, "wr_w20");
        wr(1'b0, 32'h22, 3'd1, 32'hBEEF_0000, "wr_half");
        rd(1'b0, 32'h20, 32'hBEEF_3344, "rd_half");
        wr(1'b0, 32'h23, 3'd0, 32'h7700_0000, "wr_byte3");
        rd(1'b0, 32'h20, 32'h77EF_3344, "rd_byte3");
        idle(2);

        wr(1'b0, 32'h0, 3'd2, 32'hCAFE_F00D, "wr_w0");
        errx(32'h1000, 1'b1, 3'd2, 32'h5555_5555, "err_range");
        rd(1'b0, 32'h0, 32'hCAFE_F00D, "after_err");
        errx(32'h4, 1'b0, 3'd3, 32'd0, "err_size");
        wr(1'b0, 32'hFFC, 3'd2, 32'h0BAD_CAFE, "wr_top");
        rd(1'b0, 32'hFFC, 32'h0BAD_CAFE, "rd_top");
        idle(1);

        hburst = 3'b001;
        wr(1'b0, 32'h40, 3'd2, 32'hA000_0001, "burst1", T_NSEQ);
        wr(1'b0, 32'h44, 3'd2, 32'hA000_0002, "burst2", T_SEQ);
        issue(1'b0, 32'h48, T_BUSY, 1'b1, 3'd2, 32'd0, 1'b0, "busy", 32'd0, 1'b0, 0);
        wr(1'b0, 32'h48, 3'd2, 32'hA000_0003, "burst3", T_SEQ);
        wr(1'b0, 32'h4C, 3'd2, 32'hA000_0004, "burst4", T_SEQ);
        hburst = 3'b000;
        rd(1'b0, 32'h40, 32'hA000_0001, "rb1");
        rd(1'b0, 32'h44, 32'hA000_0002, "rb2");
        rd(1'b0, 32'h48, 32'hA000_0003, "rb3");
        rd(1'b0, 32'h4C, 32'hA000_0004, "rb4");
        idle(2);

        wr(1'b1, 32'h0, 3'd2, 32'h1234_5678, "w3_wr");
        rd(1'b1, 32'h0, 32'h1234_5678, "w3_rd");
        wr(1'b1, 32'h8, 3'd2, 32'hA5A5_A5A5, "w3_wr8");
        idle(2);

        issue(1'b1, 32'h8, T_NSEQ, 1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0, "abort", 32'd0, 1'b0, 0);
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = T_IDLE;
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        check("mid_rst_ready", {31'd0, bus3.hreadyout}, 32'd1);
        check("mid_rst_resp", {31'd0, bus3.hresp}, 32'd0);
        idle(1);
        rd(1'b1, 32'h8, 32'hA5A5_A5A5, "mid_rst_keep");
        idle(1);

`ifdef AHB_SRAM_SLAVE_ALIGN_CHECK_EN
        errx(32'h3, 1'b1, 3'd1, 32'hABCD_0000, "mis_half");
        rd(1'b0, 32'h0, 32'hCAFE_F00D, "mis_half_rd");
`else
        wr(1'b0, 32'h3, 3'd1, 32'hABCD_0000, "mis_half");
        rd(1'b0, 32'h0, 32'hABCD_F00D, "mis_half_rd");
`endif
        idle(4);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave memory model with a word-organised internal array; one instance attaches to each slave port of AHB_bus (downstream of the interconnect).
- Responds to bus-issued transfers with programmable wait states, byte-lane writes and a two-cycle ERROR response.
- Gives the CRV bench a cycle-accurate, self-checking target for read/write traffic routed by the decoder and arbiter.

Parameters:
- ADDR_W, 32, width of haddr.
- DATA_W, 32, bus data width; fixed at 32 in this revision.
- DEPTH_WORDS, 1024, number of 32-bit words; valid byte range is 0 to DEPTH_WORDS*4-1 (offset within the slave region).
- WAIT_CYCLES, 0, number of hreadyout-low cycles inserted in every OKAY data phase (0 to 15).

Ports:
- hclk  in  1  bus clock; all state updates on the rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select from the bus decoder.
- haddr  in  ADDR_W  transfer address; the slave uses the low bits only.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  0=byte, 1=half, 2=word; values above 2 are illegal.
- hburst  in  3  burst type; accepted, not used for addressing.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hready  in  1  bus-level ready (previous transfer complete).
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  DATA_W  read data.

Behaviour:
- Clock and reset:
  - One clock, hclk.
  - Reset is synchronous and active-high on hreset.
- Reset values:
  - hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0.
  - Array contents are not cleared.
- Address-phase capture:
  - Capture happens when hsel & hready & htrans[1] are all high.
  - Captured fields: word index, byte offset haddr[1:0], hsize, hwrite, plus an error flag.
  - The error flag is set if the address is out of range or hsize>2.
- Zero-wait cases:
  - With hsel & hready and htrans=IDLE or BUSY, the next cycle returns OKAY with hreadyout=1 and no access.
  - Cycles without hsel are treated the same way.
- State machine, IDLE:
  - Valid capture with no error goes to WAIT if WAIT_CYCLES>0, else to DATA.
  - Valid capture with the error flag set goes to ERR1.
- State machine, WAIT:
  - hreadyout=0, hresp=0; the counter counts up.
  - After WAIT_CYCLES cycles, go to DATA.
- State machine, DATA (the single completion cycle):
  - hreadyout=1, hresp=0.
  - Read: hrdata = mem[word index], driven combinationally from the registered index.
  - Write: hwdata is merged into mem on the closing edge; only the lanes selected by hsize and the byte offset are written (little-endian).
  - A new capture in the same cycle follows the IDLE transition rules, giving back-to-back pipelining; otherwise go to IDLE.
- State machine, ERR1: hreadyout=0, hresp=1; go to ERR2.
- State machine, ERR2:
  - hreadyout=1, hresp=1; no array access and no write.
  - A capture in ERR2 is accepted following the IDLE rules.
  - If the master drives IDLE during ERR1, no new transfer is started.
- Read-after-write:
  - A read to the address just written, issued in the next address phase, returns the new data.
  - This holds because the write commits on the edge that ends the write data phase.
- Zero-wait reads: with WAIT_CYCLES=0, a read in DATA presents hrdata in the cycle immediately after the address phase.
- Idle hrdata: hrdata holds its last value outside DATA.
- Illegal sizes: byte and half accesses with a misaligned offset (a half at offset 1 or 3) are handled by the optional feature; without it, the offset is truncated to half alignment.
- Reset mid-transfer: hreset=1 in any state returns the slave to IDLE on the next edge; any pending write is discarded.

Optional Feature:
- Macro: AHB_SRAM_SLAVE_ALIGN_CHECK_EN.
- Defined: any misaligned transfer raises the error flag and takes the two-cycle ERROR path with no write. Misaligned means a half with haddr[0]=1, or a word with haddr[1:0]!=0.
- Undefined: the low address bits are truncated to the hsize alignment and the access completes OKAY.

Test Plan:
- Reset, then word write to 0x10 with 0xDEADBEEF, then read of 0x10 (WAIT_CYCLES=0) -> write completes 1 cycle after the address phase; read returns 0xDEADBEEF with hresp=0 and no low hreadyout.
- WAIT_CYCLES=3, read of 0x0 -> hreadyout low for exactly 3 cycles, then high for 1 cycle with data.
- 0x00000000 in word 4, then byte write 0xAB at 0x11, then word read of 0x10 -> 0x0000AB00.
- Access to address DEPTH_WORDS*4 -> hreadyout=0/hresp=1, then hreadyout=1/hresp=1; array unchanged; the next pipelined NONSEQ completes OKAY.
- Four-beat INCR write with a BUSY inserted between beats 2 and 3 -> BUSY answered OKAY with zero wait; all four words written; no extra access.
- hreset asserted during WAIT of a write -> slave in IDLE next cycle, hreadyout=1, target word keeps its old value. Macro defined: half write at 0x3 -> ERROR with no write. Macro undefined: the same access writes bytes 2-3.
